// File: rtl/decode_queue.sv
// Byte-granular prefetch queue between the fetch unit and the 80386 instruction
// decoder: fetch pushes up to IN_BYTES per cycle, decode retires variable-length instructions.
module decode_queue #(
    parameter int DEPTH    = 32,
    parameter int IN_BYTES = 4,
    parameter int WINDOW   = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_flush,
    input  logic                          i_fetch_valid,
    input  logic [8*IN_BYTES-1:0]         i_fetch_data,
    input  logic [$clog2(IN_BYTES):0]     i_fetch_count,
    output logic                          o_fetch_ready,
    output logic [7:0]                    o_instruction [0:WINDOW-1],
    output logic [$clog2(DEPTH):0]        o_level,
    output logic                          o_window_full,
    input  logic                          i_consume_valid,
    input  logic [$clog2(WINDOW):0]       i_consume_bytes,
    output logic                          o_error
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(IN_BYTES) + 1;

    logic [7:0]       mem_q [0:DEPTH-1];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             error_q, error_d;
    logic             ready_q, ready_d;
    logic             wfull_q, wfull_d;

    logic             push_req_s, push_bad_s, push_do_s;
    logic             cons_req_s, cons_bad_s, cons_do_s;
    logic [LVL_W-1:0] push_n_s, cons_n_s;

    // Accept/reject push and consume, then compute next pointers, level and flags.
    always_comb begin
        push_req_s = i_fetch_valid && ready_q && !i_flush;
        push_bad_s = push_req_s && (i_fetch_count > CNT_W'(IN_BYTES));
        push_do_s  = push_req_s && !push_bad_s && (i_fetch_count != '0);

        cons_req_s = i_consume_valid && !i_flush;
        cons_bad_s = cons_req_s &&
                     ((i_consume_bytes == '0) || (LVL_W'(i_consume_bytes) > level_q));
        cons_do_s  = cons_req_s && !cons_bad_s;

        push_n_s = push_do_s ? LVL_W'(i_fetch_count) : '0;
        cons_n_s = cons_do_s ? LVL_W'(i_consume_bytes) : '0;
        error_d  = push_bad_s || cons_bad_s;

        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(cons_n_s);
            tail_d  = tail_q + PTR_W'(push_n_s);
            level_d = level_q + push_n_s - cons_n_s;
        end

        // Ready and window-full are precomputed from next level so both leave flops.
        ready_d = (LVL_W'(DEPTH) - level_d) >= LVL_W'(IN_BYTES);
        wfull_d = level_d >= LVL_W'(WINDOW);
    end

    // Queue control state with asynchronous reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
            wfull_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            error_q <= error_d;
            ready_q <= ready_d;
            wfull_q <= wfull_d;
        end
    end

    // Byte storage is deliberately unreset; the window masks bytes beyond the level.
    always_ff @(posedge i_clock) begin
        if (push_do_s) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (CNT_W'(i) < i_fetch_count) begin
                    mem_q[tail_q + PTR_W'(i)] <= i_fetch_data[8*i +: 8];
                end
            end
        end
    end

    // Decode window: bytes from head, zero beyond the queued level, no push bypass.
    always_comb begin
        for (int k = 0; k < WINDOW; k++) begin
            if (LVL_W'(k) < level_q) begin
                o_instruction[k] = mem_q[head_q + PTR_W'(k)];
            end else begin
                o_instruction[k] = 8'h00;
            end
        end
    end

    assign o_level       = level_q;
    assign o_fetch_ready = ready_q;
    assign o_window_full = wfull_q;
    assign o_error       = error_q;

endmodule
